// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative ARM operand-2 shifter: shift codes,
// per-step modes, FSM states and instruction field positions.
package shifter_pkg;

    localparam int I_BIT         = 25;
    localparam int REG_SHIFT_BIT = 4;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_code_e;

    // RRX is a distinct step because the fill bit comes from the carry register.
    typedef enum logic [2:0] {
        MODE_LSL = 3'd0,
        MODE_LSR = 3'd1,
        MODE_ASR = 3'd2,
        MODE_ROR = 3'd3,
        MODE_RRX = 3'd4
    } step_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_amount_decode.sv
// Decodes the operand-2 field into a step mode, a step count and the initial
// working value/carry. A zero count means the initial values are the result.
module shift_amount_decode
    import shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic [31:0]       ir,
    input  logic [31:0]       rs_val,
    input  logic [DATA_W-1:0] rm_val,
    input  logic              cin,
    output step_mode_e        mode,
    output logic [CNT_W-1:0]  cnt,
    output logic [DATA_W-1:0] init_val,
    output logic              init_carry,
    output logic              fast_path
);

    shift_code_e code;
    logic [7:0]  amt;
    logic [4:0]  imm_n;
    logic        unused;

    assign code   = shift_code_e'(ir[6:5]);
    assign amt    = rs_val[7:0];
    assign imm_n  = ir[11:7];
    assign unused = ^{ir[31:26], ir[24:12], rs_val[31:8]};

    always_comb begin
        mode       = MODE_LSL;
        cnt        = '0;
        init_val   = rm_val;
        init_carry = cin;
        if (ir[I_BIT]) begin
            mode     = MODE_ROR;
            init_val = {{(DATA_W-8){1'b0}}, ir[7:0]};
            cnt      = CNT_W'({ir[11:8], 1'b0});
        end else if (!ir[REG_SHIFT_BIT]) begin
            mode = step_mode_e'({1'b0, ir[6:5]});
            cnt  = CNT_W'(imm_n);
            if (imm_n == 5'd0) begin
                case (code)
                    SH_LSL:         cnt = '0;
                    SH_LSR, SH_ASR: cnt = CNT_W'(32);
                    SH_ROR: begin
                        mode = MODE_RRX;
                        cnt  = CNT_W'(1);
                    end
                endcase
            end
        end else if (!ir[7]) begin
            mode = step_mode_e'({1'b0, ir[6:5]});
            if (amt != 8'd0) begin
                case (code)
                    SH_LSL, SH_LSR: begin
                        // Shifting 33+ places clears everything including the carry.
                        if (amt > 8'd32) begin
                            init_val   = '0;
                            init_carry = 1'b0;
                        end else begin
                            cnt = CNT_W'(amt);
                        end
                    end
                    SH_ASR: cnt = (amt > 8'd32) ? CNT_W'(32) : CNT_W'(amt);
                    SH_ROR: begin
                        if (amt[4:0] == 5'd0) init_carry = rm_val[DATA_W-1];
                        else                  cnt = CNT_W'(amt[4:0]);
                    end
                endcase
            end
        end
        fast_path = (cnt == '0);
    end

endmodule

// File: rtl/shifter_operand_unit.sv
// Iterative ARM addressing-mode-1 shifter: one bit per cycle, start/done handshake.
// START is taken only in IDLE or DONE; DONE is a one-cycle pulse with the result valid.
module shifter_operand_unit
    import shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [31:0]       IR,
    input  logic [DATA_W-1:0] RM_VAL,
    input  logic [31:0]       RS_VAL,
    input  logic              CIN,
    output logic [DATA_W-1:0] SHIFTER_OPERAND,
    output logic              SHIFTER_CARRY_OUT,
    output logic              BUSY,
    output logic              DONE,
    output state_e            DBG_STATE
);

    state_e            state_q, state_d;
    step_mode_e        mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] work_q;
    logic              carry_q;

    step_mode_e        dec_mode;
    logic [CNT_W-1:0]  dec_cnt;
    logic [DATA_W-1:0] dec_val;
    logic              dec_carry;
    logic              dec_fast;

    logic [DATA_W-1:0] step_val;
    logic              step_carry;
    logic              accept;
    logic              last_step;

    shift_amount_decode #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_decode (
        .ir         (IR),
        .rs_val     (RS_VAL),
        .rm_val     (RM_VAL),
        .cin        (CIN),
        .mode       (dec_mode),
        .cnt        (dec_cnt),
        .init_val   (dec_val),
        .init_carry (dec_carry),
        .fast_path  (dec_fast)
    );

    assign accept    = START && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_step = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(1));

    always_comb begin
        step_val   = work_q;
        step_carry = carry_q;
        case (mode_q)
            MODE_LSL: begin
                step_val   = {work_q[DATA_W-2:0], 1'b0};
                step_carry = work_q[DATA_W-1];
            end
            MODE_LSR: begin
                step_val   = {1'b0, work_q[DATA_W-1:1]};
                step_carry = work_q[0];
            end
            MODE_ASR: begin
                step_val   = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
                step_carry = work_q[0];
            end
            MODE_ROR: begin
                step_val   = {work_q[0], work_q[DATA_W-1:1]};
                step_carry = work_q[0];
            end
            MODE_RRX: begin
                step_val   = {carry_q, work_q[DATA_W-1:1]};
                step_carry = work_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (START) state_d = dec_fast ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (last_step) state_d = ST_DONE;
            ST_DONE:  state_d = START ? (dec_fast ? ST_DONE : ST_SHIFT) : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q            <= MODE_LSL;
            cnt_q             <= '0;
            work_q            <= '0;
            carry_q           <= 1'b0;
            SHIFTER_OPERAND   <= '0;
            SHIFTER_CARRY_OUT <= 1'b0;
        end else if (accept) begin
            mode_q  <= dec_mode;
            cnt_q   <= dec_cnt;
            work_q  <= dec_val;
            carry_q <= dec_carry;
            if (dec_fast) begin
                SHIFTER_OPERAND   <= dec_val;
                SHIFTER_CARRY_OUT <= dec_carry;
            end
        end else if (state_q == ST_SHIFT) begin
            work_q  <= step_val;
            carry_q <= step_carry;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (last_step) begin
                SHIFTER_OPERAND   <= step_val;
                SHIFTER_CARRY_OUT <= step_carry;
            end
        end
    end

    assign BUSY      = (state_q == ST_SHIFT);
    assign DONE      = (state_q == ST_DONE);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Directed bench for shifter_operand_unit: hand-computed results, carries and latencies.
module tb_shifter_operand_unit;
    import shifter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [31:0] IR = '0;
    logic [31:0] RM_VAL = '0;
    logic [31:0] RS_VAL = '0;
    logic        CIN = 1'b0;
    logic [31:0] SHIFTER_OPERAND;
    logic        SHIFTER_CARRY_OUT;
    logic        BUSY;
    logic        DONE;
    state_e      DBG_STATE;

    int checks = 0;
    int errors = 0;

    shifter_operand_unit dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .START             (START),
        .IR                (IR),
        .RM_VAL            (RM_VAL),
        .RS_VAL            (RS_VAL),
        .CIN               (CIN),
        .SHIFTER_OPERAND   (SHIFTER_OPERAND),
        .SHIFTER_CARRY_OUT (SHIFTER_CARRY_OUT),
        .BUSY              (BUSY),
        .DONE              (DONE),
        .DBG_STATE         (DBG_STATE)
    );

    always #5 CLK = ~CLK;

    // Issues one operation, scrambles inputs after the START edge, returns latency (-1 on timeout).
    task automatic do_op(input logic [31:0] ir, input logic [31:0] rm, input logic [31:0] rs,
                         input logic cin, output int lat);
        @(negedge CLK);
        IR = ir; RM_VAL = rm; RS_VAL = rs; CIN = cin; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; IR = ~ir; RM_VAL = ~rm; RS_VAL = ~rs; CIN = ~cin;
        lat = 1;
        while (!DONE && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!DONE) lat = -1;
    endtask

    task automatic check_op(input string name, input logic [31:0] exp_val, input logic exp_c,
                            input int exp_lat, input int lat);
        checks++;
        if (SHIFTER_OPERAND !== exp_val) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, SHIFTER_OPERAND, exp_val);
        end
        checks++;
        if (SHIFTER_CARRY_OUT !== exp_c) begin
            errors++;
            $display("FAIL %s carry: got %b expected %b", name, SHIFTER_CARRY_OUT, exp_c);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({SHIFTER_OPERAND, SHIFTER_CARRY_OUT, BUSY, DONE} !== 35'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h/%b/%b/%b expected 0/0/0/0",
                     SHIFTER_OPERAND, SHIFTER_CARRY_OUT, BUSY, DONE);
        end
        checks++;
        if (DBG_STATE !== ST_IDLE) begin
            errors++;
            $display("FAIL reset state: got %0d expected %0d", DBG_STATE, ST_IDLE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_immediate();
        int lat;
        do_op(32'h0200_01FF, 32'h1234_5678, 32'h0, 1'b0, lat);
        check_op("imm_rot1", 32'hC000_003F, 1'b1, 3, lat);
        do_op(32'h0200_00A5, 32'h1234_5678, 32'h0, 1'b1, lat);
        check_op("imm_rot0", 32'h0000_00A5, 1'b1, 1, lat);
    endtask

    task automatic test_imm_shift();
        int lat;
        do_op(32'h0000_0000, 32'h8000_0001, 32'h0, 1'b1, lat);
        check_op("lsl0", 32'h8000_0001, 1'b1, 1, lat);
        do_op(32'h0000_0200, 32'hF000_000F, 32'h0, 1'b0, lat);
        check_op("lsl4", 32'h0000_00F0, 1'b1, 5, lat);
        do_op(32'h0000_0060, 32'h0000_0003, 32'h0, 1'b1, lat);
        check_op("rrx", 32'h8000_0001, 1'b1, 2, lat);
        do_op(32'h0000_0040, 32'h8000_0000, 32'h0, 1'b0, lat);
        check_op("asr0", 32'hFFFF_FFFF, 1'b1, 33, lat);
    endtask

    task automatic test_reg_shift();
        int lat;
        do_op(32'h0000_0230, 32'hFFFF_FFFF, 32'h0000_0021, 1'b1, lat);
        check_op("lsr_reg33", 32'h0, 1'b0, 1, lat);
        do_op(32'h0000_0230, 32'hFFFF_FFFF, 32'h0000_0020, 1'b0, lat);
        check_op("lsr_reg32", 32'h0, 1'b1, 33, lat);
        do_op(32'h0000_0270, 32'h8000_0000, 32'h0000_0020, 1'b0, lat);
        check_op("ror_reg32", 32'h8000_0000, 1'b1, 1, lat);
        do_op(32'h0000_0270, 32'h0000_0012, 32'h0000_0004, 1'b1, lat);
        check_op("ror_reg4", 32'h2000_0001, 1'b0, 5, lat);
        do_op(32'h0000_0250, 32'h4000_0000, 32'h0000_00FF, 1'b1, lat);
        check_op("asr_reg255", 32'h0, 1'b0, 33, lat);
        do_op(32'h0000_0210, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, lat);
        check_op("lsl_reg0", 32'hDEAD_BEEF, 1'b1, 1, lat);
        do_op(32'h0000_00B0, 32'h1357_9BDF, 32'h0000_0003, 1'b1, lat);
        check_op("not_mode1", 32'h1357_9BDF, 1'b1, 1, lat);
    endtask

    task automatic test_start_ignored();
        int lat;
        do_op(32'h0000_0000, 32'hA5A5_A5A5, 32'h0, 1'b0, lat);
        check_op("hold_setup", 32'hA5A5_A5A5, 1'b0, 1, lat);
        @(posedge CLK); #1;
        checks++;
        if (DONE !== 1'b0 || DBG_STATE !== ST_IDLE) begin
            errors++;
            $display("FAIL done_pulse: got done=%b state=%0d expected done=0 state=%0d",
                     DONE, DBG_STATE, ST_IDLE);
        end
        @(negedge CLK);
        IR = 32'h0000_0440; RM_VAL = 32'h8000_0000; RS_VAL = 32'h0; CIN = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; IR = 32'h0; RM_VAL = 32'h1234_5678;
        lat = 1;
        while (!DONE && lat < 40) begin
            if (lat == 3) begin
                START = 1'b1;
                checks++;
                if (BUSY !== 1'b1 || SHIFTER_OPERAND !== 32'hA5A5_A5A5) begin
                    errors++;
                    $display("FAIL busy_hold: got busy=%b result=%h expected busy=1 result=a5a5a5a5",
                             BUSY, SHIFTER_OPERAND);
                end
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        START = 1'b0;
        if (!DONE) lat = -1;
        check_op("asr8_ignored_start", 32'hFF80_0000, 1'b0, 9, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'h0200_01FF, 32'h0, 32'h0, 1'b0, lat);
        check_op("b2b_first", 32'hC000_003F, 1'b1, 3, lat);
        do_op(32'h0000_0060, 32'h0000_0002, 32'h0, 1'b0, lat);
        check_op("b2b_second", 32'h0000_0001, 1'b0, 2, lat);
        @(posedge CLK); #1;
        checks++;
        if (DONE !== 1'b0 || SHIFTER_OPERAND !== 32'h0000_0001) begin
            errors++;
            $display("FAIL b2b_idle: got done=%b result=%h expected done=0 result=00000001",
                     DONE, SHIFTER_OPERAND);
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen_done;
        do_op(32'h0000_0040, 32'h8000_0000, 32'h0, 1'b0, lat);
        check_op("abort_setup", 32'hFFFF_FFFF, 1'b1, 33, lat);
        @(negedge CLK);
        IR = 32'h0000_0040; RM_VAL = 32'h8000_0000; CIN = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({SHIFTER_OPERAND, SHIFTER_CARRY_OUT, BUSY, DONE} !== 35'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %h/%b/%b/%b expected 0/0/0/0",
                     SHIFTER_OPERAND, SHIFTER_CARRY_OUT, BUSY, DONE);
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (DONE) seen_done++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_imm_shift();
        test_reg_shift();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
